mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised successor to the team's fixed mod-6 up counter. Counts up or down modulo a runtime-programmable terminal value. Supports enable, synchronous clear and load, and selectable wrap or saturate behaviour. Provides a combinational terminal-count output for cascading multiple instances, plus registered wrap and sticky overflow status. Used as the general-purpose event/timebase counter in datapath and control blocks.

## Interface
Parameters:
- WIDTH, default 3: counter width in bits; legal range 2..32.
- RESET_VAL, default 0: value loaded into cnt on rst; must be <= 2^WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  count enable; one step per cycle while high.
- clr  input  1  synchronous clear; highest synchronous priority.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value for load; clamped to max_val.
- dir  input  1  1 = count up, 0 = count down.
- mode  input  1  0 = wrap, 1 = saturate.
- max_val  input  WIDTH  terminal value; count range is 0..max_val inclusive.
- cnt  output  WIDTH  registered count.
- tc  output  1  combinational terminal count; used for cascading.
- wrap  output  1  registered one-cycle pulse following a wrap.
- ovf  output  1  registered sticky overflow/underflow flag.

## Operation
- Reset: rst=1 forces cnt=RESET_VAL, wrap=0, ovf=0 immediately, without waiting for clk. Release is synchronous to the next edge.
- Synchronous priority per edge: clr > load > en step > hold.
- clr: cnt<=0, ovf<=0, wrap<=0. Ignores en, load and dir.
- load:
  - If load_val <= max_val, cnt<=load_val; otherwise cnt<=max_val.
  - wrap<=0; ovf is unchanged.
- Step up (en=1, dir=1):
  - cnt<max_val: cnt<=cnt+1.
  - cnt>=max_val, mode=0: cnt<=0, wrap<=1, ovf<=1.
  - cnt>=max_val, mode=1: cnt<=max_val (hold), wrap<=0, ovf<=1.
- Step down (en=1, dir=0):
  - cnt>0: cnt<=cnt-1.
  - cnt==0, mode=0: cnt<=max_val, wrap<=1, ovf<=1.
  - cnt==0, mode=1: cnt holds 0, ovf<=1.
- Stale count after max_val is lowered at runtime:
  - Up mode: cnt>max_val is treated as the terminal condition and wraps or saturates as above. In saturate mode it saturates to the new max_val.
  - Down mode: cnt decrements normally from its current value.
- max_val=0: cnt stays 0; tc=en on every cycle; wrap pulses every enabled cycle in mode 0.
- tc = en & ~clr & ~load & ((dir & cnt>=max_val) | (~dir & cnt==0)).
  - Purely combinational; no registered term.
  - Cascading: connect tc of the lower stage to en of the upper stage.
- wrap is high for exactly one cycle after each wrap event; otherwise it is 0.
- ovf clears only on rst or clr.
- All arithmetic is unsigned, modulo 2^WIDTH. Internally no value outside 0..max_val is produced except when inherited from a stale count.

## Timing
- Latency: one clk from en/clr/load sampled to the new cnt.
- wrap and ovf update on the same edge as the cnt transition that causes them.
- tc is valid in the same cycle as the cnt it describes. It is combinational from en, clr, load, dir, max_val and cnt.
- Changing dir, mode or max_val takes effect on the next edge; nothing is pipelined.
- rst asserted mid-count aborts immediately. There is no recovery state.

## Test plan
- Reset then up-wrap:
  - Stimulus: WIDTH=3, rst pulse, then en=1, dir=1, mode=0, max_val=5 for 8 cycles.
  - Required: cnt 0,1,2,3,4,5,0,1,2. tc high while cnt=5. wrap high the cycle cnt=0 after 5. ovf=1 from that edge onward.
- Down-wrap:
  - Stimulus: load 2, then dir=0, en=1, max_val=5.
  - Required: cnt 2,1,0,5,4. wrap pulse at the 0->5 transition.
- Saturate:
  - Stimulus: mode=1, load 4, dir=1, en=1, max_val=5, 4 cycles.
  - Required: cnt 4,5,5,5. wrap stays 0. ovf=1 after the first blocked step.
- Priority and clamp:
  - Stimulus 1: clr=1, load=1, en=1 together.
    - Required: cnt=0, ovf=0.
  - Stimulus 2: load=1, load_val=7, max_val=5.
    - Required: cnt=5.
  - Stimulus 3: en=1 with load=1.
    - Required: load wins and tc=0.
- Runtime max_val shrink and async reset:
  - Stimulus: cnt=5 counting up, max_val changed to 3.
    - Required: next cnt=0 in mode 0.
  - Stimulus: rst asserted between clock edges.
    - Required: cnt=RESET_VAL before the next edge.
- Cascade:
  - Stimulus: two instances, max_val=5 each; low.tc drives high.en; 36 enabled cycles.
  - Required: high.cnt advances once per low wrap. Both stages reach 0 together, and high.wrap pulses once.

Source files
------------

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: up/down counter modulo a runtime terminal value, wrap or saturate
//   clk, rst      : clock, asynchronous active-high reset
//   en, clr, load : step enable, synchronous clear, synchronous load (clr > load > en)
//   load_val      : load value, clamped to max_val
//   dir, mode     : 1 = up / 0 = down; 0 = wrap / 1 = saturate
//   max_val       : terminal value, count range 0..max_val
//   cnt           : registered count
//   tc            : combinational terminal count for cascading into the next stage's en
//   wrap, ovf     : one-cycle wrap pulse, sticky overflow/underflow flag
module mod_updown_counter #(
    parameter int WIDTH = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);
    logic             term;
    logic             step_term;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;
    logic             ovf_nxt;

    // >= rather than == so a stale count above a lowered max_val still terminates
    assign term      = dir ? (cnt >= max_val) : (cnt == '0);
    assign tc        = en & ~clr & ~load & term;
    assign step_term = en & term;

    always_comb begin
        step_val = dir ? (term ? (mode ? max_val : '0) : cnt + 1'b1)
                       : (term ? (mode ? '0 : max_val) : cnt - 1'b1);
        cnt_nxt  = clr  ? '0
                 : load ? ((load_val > max_val) ? max_val : load_val)
                 : en   ? step_val
                 : cnt;
        wrap_nxt = ~clr & ~load & step_term & ~mode;
        ovf_nxt  = ~clr & (ovf | (~load & step_term));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= RESET_VAL;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            wrap <= wrap_nxt;
            ovf  <= ovf_nxt;
        end
    end
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed self-checking bench for mod_updown_counter and a two-stage cascade
module tb_mod_updown_counter;
    logic       clk = 1'b0;
    logic       rst, en, clr, load, dir, mode, c_en;
    logic [2:0] load_val, max_val, lo_cnt, hi_cnt, cnt;
    logic       tc, wrap, ovf, lo_tc, lo_wrap, lo_ovf, hi_tc, hi_wrap, hi_ovf;
    int         total = 0;
    int         bad = 0;
    int         hw = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(3), .RESET_VAL(3'd0)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .mode(mode), .max_val(max_val), .cnt(cnt), .tc(tc), .wrap(wrap), .ovf(ovf)
    );

    mod_updown_counter #(.WIDTH(3), .RESET_VAL(3'd0)) lo (
        .clk(clk), .rst(rst), .en(c_en), .clr(1'b0), .load(1'b0), .load_val(3'd0),
        .dir(1'b1), .mode(1'b0), .max_val(3'd5), .cnt(lo_cnt), .tc(lo_tc), .wrap(lo_wrap), .ovf(lo_ovf)
    );

    mod_updown_counter #(.WIDTH(3), .RESET_VAL(3'd0)) hi (
        .clk(clk), .rst(rst), .en(lo_tc), .clr(1'b0), .load(1'b0), .load_val(3'd0),
        .dir(1'b1), .mode(1'b0), .max_val(3'd5), .cnt(hi_cnt), .tc(hi_tc), .wrap(hi_wrap), .ovf(hi_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        static logic [2:0] up_seq[8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
        static logic [2:0] dn_seq[4] = '{3'd1, 3'd0, 3'd5, 3'd4};
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 3'd0;
        dir = 1'b1; mode = 1'b0; max_val = 3'd5; c_en = 1'b0;
        #12;
        chk("rst_cnt", cnt, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        #1;
        chk("up_tc0", tc, 0);
        for (int i = 0; i < 8; i++) begin
            chk("up_tc", tc, (i == 5) ? 1 : 0);
            tick();
            chk("up_cnt", cnt, up_seq[i]);
            chk("up_wrap", wrap, (i == 5) ? 1 : 0);
            chk("up_ovf", ovf, (i >= 5) ? 1 : 0);
        end
        load = 1'b1; load_val = 3'd2; dir = 1'b0;
        #1;
        chk("load_tc", tc, 0);
        tick();
        chk("load_cnt", cnt, 2);
        chk("load_wrap", wrap, 0);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("dn_tc", tc, (i == 2) ? 1 : 0);
            tick();
            chk("dn_cnt", cnt, dn_seq[i]);
            chk("dn_wrap", wrap, (i == 2) ? 1 : 0);
        end
        clr = 1'b1; load = 1'b1; load_val = 3'd4;
        #1;
        chk("clr_tc", tc, 0);
        tick();
        chk("clr_cnt", cnt, 0);
        chk("clr_ovf", ovf, 0);
        chk("clr_wrap", wrap, 0);
        clr = 1'b0; mode = 1'b1; dir = 1'b1;
        tick();
        chk("sat_load", cnt, 4);
        load = 1'b0;
        tick();
        chk("sat_c1", cnt, 5);
        chk("sat_ovf1", ovf, 0);
        tick();
        chk("sat_c2", cnt, 5);
        chk("sat_ovf2", ovf, 1);
        chk("sat_wrap2", wrap, 0);
        tick();
        chk("sat_c3", cnt, 5);
        chk("sat_wrap3", wrap, 0);
        load = 1'b1; load_val = 3'd7;
        tick();
        chk("clamp_cnt", cnt, 5);
        chk("clamp_ovf", ovf, 1);
        load_val = 3'd0;
        tick();
        load = 1'b0; dir = 1'b0;
        tick();
        chk("satdn_cnt", cnt, 0);
        chk("satdn_wrap", wrap, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0; load = 1'b1; load_val = 3'd5; mode = 1'b0; dir = 1'b1;
        tick();
        load = 1'b0; max_val = 3'd3;
        #1;
        chk("shrink_tc", tc, 1);
        tick();
        chk("shrink_cnt", cnt, 0);
        chk("shrink_wrap", wrap, 1);
        chk("shrink_ovf", ovf, 1);
        tick();
        chk("shrink_next", cnt, 1);
        chk("shrink_wrap2", wrap, 0);
        max_val = 3'd7; load = 1'b1; load_val = 3'd6;
        tick();
        load = 1'b0; max_val = 3'd3; mode = 1'b1;
        tick();
        chk("shrink_sat", cnt, 3);
        clr = 1'b1;
        tick();
        clr = 1'b0; max_val = 3'd0; mode = 1'b0;
        #1;
        chk("max0_tc", tc, 1);
        tick();
        chk("max0_cnt", cnt, 0);
        chk("max0_wrap", wrap, 1);
        tick();
        chk("max0_wrap2", wrap, 1);
        en = 1'b0;
        #1;
        chk("max0_tc_off", tc, 0);
        max_val = 3'd5; load = 1'b1; load_val = 3'd4;
        tick();
        load = 1'b0;
        chk("pre_rst_cnt", cnt, 4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_cnt", cnt, 0);
        chk("async_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        c_en = 1'b1;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (hi_wrap) hw++;
            if (i == 5) begin
                chk("casc_lo6", lo_cnt, 0);
                chk("casc_hi6", hi_cnt, 1);
            end
        end
        chk("casc_lo_end", lo_cnt, 0);
        chk("casc_hi_end", hi_cnt, 0);
        chk("casc_hi_wrap", hi_wrap, 1);
        chk("casc_wraps", hw, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
